// File: rtl/cache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with line refill over a req/ack bus.
// Define CACHE_STATS_EN to add the hit_count / miss_count performance counters.
module cache_dm #(
  parameter int unsigned CACHE_LINES      = 8,
  parameter int unsigned CACHE_LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  input  logic        req_valid,
  input  logic        op_type,
  input  logic [31:0] address,
  input  logic [31:0] i_val,
  output logic [31:0] o_val,
  output logic        ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned OffW = $clog2(CACHE_LINE_WORDS);
  localparam int unsigned IdxW = $clog2(CACHE_LINES);
  localparam int unsigned TagW = 30 - OffW - IdxW;

  typedef enum logic [2:0] {StIdle, StLookup, StRefill, StWrite, StResp} state_e;

  state_e            state_q;
  logic [31:2]       addr_q;
  logic              is_store_q;
  logic [31:0]       wdata_q;
  logic              hit_q;
  logic [31:0]       word_q;
  logic [OffW-1:0]   cnt_q;

  logic              ready_q;
  logic [31:0]       o_val_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic [CACHE_LINES-1:0] valid_q;
  logic [TagW-1:0]        tag_q  [CACHE_LINES];
  logic [31:0]            data_q [CACHE_LINES][CACHE_LINE_WORDS];

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  logic [OffW-1:0] req_off;
  logic [IdxW-1:0] req_idx;
  logic [TagW-1:0] req_tag;
  logic [OffW-1:0] cnt_nxt;
  logic            lookup_hit;
  logic            ack;
  logic            last_word;
  logic            unused_addr_bits;

  assign req_off    = addr_q[OffW+1:2];
  assign req_idx    = addr_q[IdxW+OffW+1:OffW+2];
  assign req_tag    = addr_q[31:IdxW+OffW+2];
  assign cnt_nxt    = cnt_q + OffW'(1);
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // An ack only counts while a request is actually outstanding.
  assign ack        = mem_ack && mem_req_q;
  assign last_word  = &cnt_q;
  assign unused_addr_bits = ^address[1:0];

  assign ready     = ready_q;
  assign o_val     = o_val_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      o_val_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      valid_q     <= '0;
`ifdef CACHE_STATS_EN
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // While ready is high the CPU may still be holding the request just completed.
          if (req_valid && !ready_q) begin
            addr_q     <= address[31:2];
            is_store_q <= op_type;
            wdata_q    <= i_val;
            state_q    <= StLookup;
          end
        end
        StLookup: begin
          hit_q  <= lookup_hit;
          word_q <= data_q[req_idx][req_off];
          cnt_q  <= '0;
`ifdef CACHE_STATS_EN
          if (lookup_hit) hit_cnt_q <= hit_cnt_q + 32'd1;
          else            miss_cnt_q <= miss_cnt_q + 32'd1;
`endif
          if (is_store_q) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {addr_q, 2'b00};
            mem_wdata_q <= wdata_q;
            state_q     <= StWrite;
          end else if (lookup_hit) begin
            state_q <= StResp;
          end else begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {addr_q[31:OffW+2], {OffW{1'b0}}, 2'b00};
            state_q    <= StRefill;
          end
        end
        StRefill: begin
          if (ack) begin
            data_q[req_idx][cnt_q] <= mem_rdata;
            if (cnt_q == req_off) word_q <= mem_rdata;
            cnt_q      <= cnt_nxt;
            mem_addr_q <= {addr_q[31:OffW+2], cnt_nxt, 2'b00};
            if (last_word) begin
              mem_req_q        <= 1'b0;
              valid_q[req_idx] <= 1'b1;
              tag_q[req_idx]   <= req_tag;
              state_q          <= StResp;
            end
          end
        end
        StWrite: begin
          if (ack) begin
            // No-write-allocate: only a resident line is updated.
            if (hit_q) data_q[req_idx][req_off] <= wdata_q;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= StResp;
          end
        end
        StResp: begin
          ready_q <= 1'b1;
          o_val_q <= is_store_q ? 32'd0 : word_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_dm.sv
// Scoreboard bench for cache_dm: CPU driver, randomised-latency memory responder and response monitor.
module tb_cache_dm;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        op_type;
  logic [31:0] address;
  logic [31:0] i_val;
  logic [31:0] o_val;
  logic        ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_dm dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CACHE_STATS_EN
    .hit_count (hit_count),
    .miss_count(miss_count),
`endif
    .req_valid (req_valid),
    .op_type   (op_type),
    .address   (address),
    .i_val     (i_val),
    .o_val     (o_val),
    .ready     (ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_tx_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          mreq_cycles = 0;
  int          acks_done = 0;
  int          ack_limit = 1 << 30;
  int          last_ack_cyc = 0;
  mem_tx_t     exp_mem[$];
  logic [31:0] exp_resp[$];
  logic [31:0] mem_over[logic [31:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_over.exists(a)) return mem_over[a];
    return a ^ 32'hA5A5_A5A5;
  endfunction

  // Memory responder: random gaps, plus stray acks while no request is pending.
  initial begin
    mem_tx_t e;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (mem_req) begin
        if (acks_done < ack_limit && $urandom_range(0, 2) != 0) begin
          check_eq("mem_tx_expected", 32'(exp_mem.size() > 0), 32'd1);
          if (exp_mem.size() > 0) begin
            e = exp_mem.pop_front();
            check_eq("mem_we", 32'(mem_we), 32'(e.we));
            check_eq("mem_addr", mem_addr, e.addr);
            if (e.we) check_eq("mem_wdata", mem_wdata, e.wdata);
          end
          if (mem_we) mem_over[mem_addr] = mem_wdata;
          else        mem_rdata = mem_rd(mem_addr);
          mem_ack      = 1'b1;
          acks_done++;
          last_ack_cyc = cyc;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // Response monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_req) mreq_cycles <= mreq_cycles + 1;
    if (!rst && ready) begin
      check_eq("resp_expected", 32'(exp_resp.size() > 0), 32'd1);
      if (exp_resp.size() > 0) check_eq("o_val", o_val, exp_resp.pop_front());
    end
  end

  // n_mem: 0 = hit (no bus traffic), 1 = write-through, 4 = line refill.
  task automatic cpu_op(input logic op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_val, input int n_mem);
    int lat;
    int mreq0;
    mem_tx_t t;
    exp_resp.push_back(exp_val);
    if (n_mem == 1) begin
      t = '{we: 1'b1, addr: {addr[31:2], 2'b00}, wdata: wdata};
      exp_mem.push_back(t);
    end else if (n_mem == 4) begin
      for (int i = 0; i < 4; i++) begin
        t = '{we: 1'b0, addr: {addr[31:4], 4'h0} + 32'(4 * i), wdata: 32'd0};
        exp_mem.push_back(t);
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    op_type   = op;
    address   = addr;
    i_val     = wdata;
    mreq0     = mreq_cycles;
    lat       = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ready && lat < 200);
    check_eq("ready_seen", 32'(ready), 32'd1);
    req_valid = 1'b0;
    if (n_mem == 0) begin
      check_eq("hit_latency", 32'(lat), 32'd3);
      check_eq("hit_no_mem_req", 32'(mreq_cycles - mreq0), 32'd0);
    end else begin
      check_eq("ack_to_ready", 32'(cyc - last_ack_cyc), 32'd2);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wait_cyc;
    mem_tx_t t;
    rst       = 1'b1;
    req_valid = 1'b0;
    op_type   = 1'b0;
    address   = '0;
    i_val     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_o_val", o_val, 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    cpu_op(1'b0, 32'h40, 32'd0, 32'hA5A5_A5E5, 4);
    cpu_op(1'b0, 32'h40, 32'd0, 32'hA5A5_A5E5, 0);
    cpu_op(1'b1, 32'h44, 32'h1234_5678, 32'd0, 1);
    cpu_op(1'b0, 32'h44, 32'd0, 32'h1234_5678, 0);
`ifdef CACHE_STATS_EN
    check_eq("hit_count", hit_count, 32'd3);
    check_eq("miss_count", miss_count, 32'd1);
`endif

    // Store miss must not allocate.
    cpu_op(1'b1, 32'h200, 32'hCAFE_F00D, 32'd0, 1);
    cpu_op(1'b0, 32'h200, 32'd0, 32'hCAFE_F00D, 4);

    // Conflict on index 4, with memory changed behind the cache.
    cpu_op(1'b0, 32'hC0, 32'd0, 32'h40 ^ 32'hA5A5_A5A5 ^ 32'h80, 4);
    mem_over[32'h40] = 32'h5EED_0040;
    cpu_op(1'b0, 32'h40, 32'd0, 32'h5EED_0040, 4);
    cpu_op(1'b0, 32'h44, 32'd0, 32'h1234_5678, 0);

    // Reset after the second refill ack of a miss.
    ack_limit = acks_done + 2;
    for (int i = 0; i < 2; i++) begin
      t = '{we: 1'b0, addr: 32'h100 + 32'(4 * i), wdata: 32'd0};
      exp_mem.push_back(t);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    op_type   = 1'b0;
    address   = 32'h104;
    wait_cyc  = 0;
    while (acks_done < ack_limit && wait_cyc < 200) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    check_eq("partial_acks", 32'(acks_done), 32'(ack_limit));
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("mem_req_after_rst", 32'(mem_req), 32'd0);
    ack_limit = 1 << 30;
    repeat (3) @(posedge clk);
    check_eq("no_ready_after_rst", 32'(exp_resp.size()), 32'd0);
    cpu_op(1'b0, 32'h104, 32'd0, 32'h104 ^ 32'hA5A5_A5A5, 4);
    cpu_op(1'b0, 32'h104, 32'd0, 32'h104 ^ 32'hA5A5_A5A5, 0);
    cpu_op(1'b0, 32'h20C, 32'd0, 32'h20C ^ 32'hA5A5_A5A5, 4);

    repeat (4) @(posedge clk);
    check_eq("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
    check_eq("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/cache_dm.md
# cache_dm

Parametrised direct-mapped, write-through, no-write-allocate data cache between the RISC-V load/store unit and the word-wide memory bus. Replaces the fixed preload-only cache array with a clocked block that performs tag lookup, line refill over a request/acknowledge memory handshake and write-through stores. Optional hit/miss counters support performance bring-up.

## Interface
- CACHE_LINES, 8: number of lines; power of two, at least 2.
- CACHE_LINE_WORDS, 4: 32-bit words per line; power of two, at least 2.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request; held stable, with its qualifiers, until `ready`.
- op_type  in  1  0 = load, 1 = store.
- address  in  32  byte address; bits [1:0] ignored.
- i_val  in  32  store data.
- o_val  out  32  load data; valid while `ready` = 1.
- ready  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request; held until `mem_ack`.
- mem_we  out  1  1 = memory write.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  memory write data.
- mem_ack  in  1  memory completion; `mem_rdata` is valid in the same cycle.
- mem_rdata  in  32  memory read data.

## Operation
- Address split: offset = [OB+1:2], where OB = log2(CACHE_LINE_WORDS).
- Index = next log2(CACHE_LINES) bits; tag = remaining upper bits.
- Storage: a valid bit, tag and data words per line.
- FSM states: IDLE, LOOKUP, REFILL, WRITE, RESP.
- IDLE: when `req_valid` = 1, latch `address`, `op_type` and `i_val`; go to LOOKUP.
- LOOKUP, load hit: go to RESP.
- LOOKUP, load miss: go to REFILL with word counter = 0.
- LOOKUP, store: go to WRITE.
- REFILL:
  - `mem_req` = 1, `mem_we` = 0, `mem_addr` = {tag, index, counter, 2'b00}.
  - Each `mem_ack` writes `mem_rdata` into data[index][counter] and increments the counter.
  - The requested word is captured as it arrives.
  - On the ack with counter = CACHE_LINE_WORDS-1: set valid, write tag, go to RESP.
  - Refill order is always word 0 upward; there is no critical-word-first.
- WRITE:
  - `mem_req` = 1, `mem_we` = 1, `mem_addr` = latched address, `mem_wdata` = latched `i_val`.
  - On `mem_ack`: if the store hit, update the cached word; a store miss does not allocate. Go to RESP.
- RESP:
  - `ready` = 1; `o_val` = load word, or 0 for a store. Go to IDLE.
- `req_valid` is ignored outside IDLE.
- `mem_ack` is ignored when `mem_req` = 0.
- A new request may be accepted the cycle after RESP.

## Timing
- Reset values: `ready` = 0, `o_val` = 0, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Reset also clears all valid bits, puts the FSM in IDLE and clears the counters. Data and tag arrays are not cleared.
- `rst` asserted mid-REFILL or mid-WRITE: `mem_req` is 0 from the next edge. The partial line stays invalid and any later `mem_ack` is ignored.
- Load hit: request accepted at edge 0; `ready` high in the cycle after edge 2 (3 cycles from `req_valid` to `ready`).
- Load miss: `ready` one cycle after the final refill `mem_ack` edge.
- Store: `ready` one cycle after the `mem_ack` edge.
- `mem_req` rises in the cycle after LOOKUP. During REFILL it stays high between words, with the address changing on each ack edge.
- Memory outputs are registered; no combinational path from `mem_ack` to `mem_req`.

## Configuration
- CACHE_STATS_EN defined:
  - Adds output ports `hit_count` [31:0] and `miss_count` [31:0], both reset to 0.
  - Each is incremented in LOOKUP for loads and stores alike; both wrap modulo 2^32.
- CACHE_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then load 0x0000_0040 with memory word at address A = value A ^ 0xA5A5_A5A5:
  - Four read handshakes to 0x40, 0x44, 0x48, 0x4C.
  - `o_val` = 0xA5A5_A5E5.
  - Repeating the load returns the same value with `ready` 3 cycles after `req_valid` and no `mem_req`.
- Store 0x1234_5678 to 0x44 after the above:
  - One write handshake, `mem_wdata` = 0x1234_5678.
  - A following load of 0x44 hits and returns 0x1234_5678.
- Store to uncached 0x200 with default parameters:
  - Write handshake only.
  - A following load of 0x200 misses and refills 0x200 to 0x20C.
- Conflict: load 0x40, then 0xC0 (same index, different tag), then 0x40:
  - Three refills; the last returns the refreshed memory value.
- Assert `rst` for one cycle after the second refill ack of a miss:
  - `mem_req` = 0 the next cycle.
  - A later load of the same address performs a full 4-word refill.
- With CACHE_STATS_EN, run the first two scenarios (load miss, load hit, store hit, load hit):
  - `hit_count` = 3, `miss_count` = 1.
